// File: rtl/shiftreg_scan_ctrl.sv
`timescale 1ns/1ps
// Scan controller for a PISO button shift register with an Avalon-MM register block.
// Optional build macro SHIFTREG_DEBOUNCE_EN: buttons update only after 3 identical differing raw scans.
module shiftreg_scan_ctrl #(
  parameter int CLK_DIV       = 25,
  parameter int NUM_BITS      = 16,
  parameter int SCAN_INTERVAL = 50000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                shiftreg_clk,
  output logic                shiftreg_loadn,
  input  logic                shiftreg_out,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic                irq
);

  // state  | meaning
  // IDLE   | waiting for interval wrap, trigger or pending scan
  // LOAD   | loadn low, register captures parallel inputs
  // SETTLE | loadn high; doubles as the low phase of the first bit
  // SHIFT  | shift clock high/low phases, sample at end of each low phase
  // DONE   | publish result, accumulate change flags
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SHIFT, S_DONE} state_t;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(SCAN_INTERVAL);
  localparam int BIT_W = $clog2(NUM_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                phase_hi;
  logic [NUM_BITS-1:0] acc;
  logic                pending;
  logic [CNT_W-1:0]    int_cnt;
  logic [1:0]          sync_q;
  logic                enable;
  logic [NUM_BITS-1:0] changed;
  logic [NUM_BITS-1:0] irq_en;
  logic [NUM_BITS-1:0] raw_scan;
  logic [NUM_BITS-1:0] set_mask;
  logic [NUM_BITS-1:0] clr_mask;
  logic [31:0]         rd_mux;
  logic                update_ok;
  logic                unused_wdata;

  wire wrap     = (int_cnt == CNT_W'(SCAN_INTERVAL - 1));
  wire ctrl_wr  = avs_write && (avs_address == 2'd3);
  wire scan_req = (wrap && enable) || (ctrl_wr && avs_writedata[1]);
  wire div_tc   = (div_cnt == '0);
  wire busy     = (state != S_IDLE);

  assign raw_scan     = (ACTIVE_LOW != 0) ? ~acc : acc;
  assign unused_wdata = &{1'b0, avs_writedata};

`ifdef SHIFTREG_DEBOUNCE_EN
  logic [NUM_BITS-1:0] last_raw;
  logic [1:0]          match_cnt;
  logic [1:0]          next_match;
  assign next_match = (raw_scan == last_raw) ? match_cnt + 2'd1 : 2'd1;
  assign update_ok  = (raw_scan != buttons) && (next_match == 2'd3);
`else
  assign update_ok = 1'b1;
`endif

  assign set_mask = (state == S_DONE && update_ok) ? (buttons ^ raw_scan) : '0;
  assign clr_mask = (avs_write && avs_address == 2'd1) ? avs_writedata[NUM_BITS-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      phase_hi       <= 1'b0;
      acc            <= '0;
      pending        <= 1'b0;
      shiftreg_clk   <= 1'b0;
      shiftreg_loadn <= 1'b1;
      buttons        <= '0;
      buttons_valid  <= 1'b0;
`ifdef SHIFTREG_DEBOUNCE_EN
      last_raw       <= '0;
      match_cnt      <= '0;
`endif
    end else begin
      buttons_valid <= 1'b0;
      if (busy && scan_req) pending <= 1'b1;
      case (state)
        S_IDLE: if (scan_req || pending) begin
          state          <= S_LOAD;
          shiftreg_loadn <= 1'b0;
          div_cnt        <= DIV_MAX;
          bit_cnt        <= BIT_W'(NUM_BITS);
          pending        <= 1'b0;
        end
        S_LOAD: if (div_tc) begin
          state          <= S_SETTLE;
          shiftreg_loadn <= 1'b1;
          div_cnt        <= DIV_MAX;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
        S_SETTLE, S_SHIFT: if (!div_tc) begin
          div_cnt <= div_cnt - 1'b1;
        end else if (phase_hi) begin
          shiftreg_clk <= 1'b0;
          phase_hi     <= 1'b0;
          div_cnt      <= DIV_MAX;
        end else begin
          // first sampled bit walks up to the MSB after NUM_BITS shifts
          acc     <= (acc << 1) | NUM_BITS'(sync_q[1]);
          bit_cnt <= bit_cnt - 1'b1;
          div_cnt <= DIV_MAX;
          if (bit_cnt == BIT_W'(1)) begin
            state <= S_DONE;
          end else begin
            state        <= S_SHIFT;
            shiftreg_clk <= 1'b1;
            phase_hi     <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (update_ok) begin
            buttons       <= raw_scan;
            buttons_valid <= 1'b1;
          end
`ifdef SHIFTREG_DEBOUNCE_EN
          last_raw <= raw_scan;
          if (raw_scan == buttons || update_ok) match_cnt <= 2'd0;
          else match_cnt <= next_match;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux = 32'(buttons);
      2'd1: rd_mux = 32'(changed);
      2'd2: rd_mux = 32'(irq_en);
      2'd3: rd_mux = {29'b0, busy, 1'b0, enable};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b00;
      int_cnt      <= '0;
      enable       <= 1'b1;
      changed      <= '0;
      irq_en       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      sync_q  <= {sync_q[0], shiftreg_out};
      int_cnt <= wrap ? '0 : int_cnt + 1'b1;
      if (ctrl_wr) enable <= avs_writedata[0];
      if (avs_write && avs_address == 2'd2) irq_en <= avs_writedata[NUM_BITS-1:0];
      // a flag set by DONE survives a simultaneous write-1-to-clear
      changed <= (changed & ~clr_mask) | set_mask;
      irq     <= |(changed & irq_en);
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_shiftreg_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for shiftreg_scan_ctrl with a behavioural PISO register model.
module tb_shiftreg_scan_ctrl;
  localparam int CD = 4;
  localparam int NB = 16;
  localparam int SI = 400;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          shiftreg_clk, shiftreg_loadn;
  logic          shiftreg_out = 1'b1;
  logic [NB-1:0] buttons;
  logic          buttons_valid;
  logic [1:0]    avs_address = 2'd0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = 32'd0;
  logic          irq;

  logic [15:0]   pattern = 16'hFFFE;
  logic [15:0]   model_sr = 16'hFFFF;
  logic          prev_sclk = 1'b0;
  int            checks = 0;
  int            failures = 0;

  shiftreg_scan_ctrl #(.CLK_DIV(CD), .NUM_BITS(NB), .SCAN_INTERVAL(SI), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .shiftreg_clk(shiftreg_clk), .shiftreg_loadn(shiftreg_loadn),
    .shiftreg_out(shiftreg_out), .buttons(buttons), .buttons_valid(buttons_valid),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq));

  always #5 clk = ~clk;

  // parallel load while loadn low, shift on shift-clock rising edge, MSB out first
  always @(negedge clk) begin
    if (!shiftreg_loadn) model_sr = pattern;
    else if (shiftreg_clk && !prev_sclk) model_sr = {model_sr[14:0], 1'b1};
    prev_sclk = shiftreg_clk;
    shiftreg_out = model_sr[15];
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    checks++; if (shiftreg_clk !== 1'b0) begin failures++; $display("FAIL rst_sclk got %b want 0", shiftreg_clk); end
    checks++; if (shiftreg_loadn !== 1'b1) begin failures++; $display("FAIL rst_loadn got %b want 1", shiftreg_loadn); end
    checks++; if (buttons !== 16'h0) begin failures++; $display("FAIL rst_buttons got %h want 0", buttons); end
    checks++; if (buttons_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", buttons_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b want 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL rst_readdata got %h want 0", avs_readdata); end
    bus_read(2'd3, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rst_ctrl got %h want 1", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_changed got %h want 0", rd); end
    bus_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_irq_en got %h want 0", rd); end
  endtask

  task automatic test_scan;
    int n, off, lows, rises;
    logic prev;
    logic [31:0] rd;
    n = 0;
    while (shiftreg_loadn && n < 500) begin @(posedge clk); #1; n++; end
    checks++; if (shiftreg_loadn !== 1'b0) begin failures++; $display("FAIL scan_start timeout loadn=%b", shiftreg_loadn); end
    off = 0; lows = 1; rises = 0; prev = shiftreg_clk;
    while (!buttons_valid && off < 300) begin
      @(posedge clk); #1; off++;
      if (!shiftreg_loadn) lows++;
      if (shiftreg_clk && !prev) rises++;
      prev = shiftreg_clk;
    end
    checks++; if (off != 129) begin failures++; $display("FAIL scan_latency got %0d want 129", off); end
    checks++; if (lows != CD) begin failures++; $display("FAIL loadn_low_cycles got %0d want %0d", lows, CD); end
    checks++; if (rises != NB - 1) begin failures++; $display("FAIL sclk_rises got %0d want %0d", rises, NB - 1); end
    checks++; if (buttons !== 16'h0001) begin failures++; $display("FAIL scan_buttons got %h want 0001", buttons); end
    @(posedge clk); #1;
    checks++; if (buttons_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got %b want 0", buttons_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq got %b want 0", irq); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL reg_buttons got %h want 1", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL first_changed got %h want 1", rd); end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL changed_clear got %h want 0", rd); end
  endtask

  task automatic test_irq;
    int n;
    logic [31:0] rd;
    bus_write(2'd2, 32'h8000);
    pattern = 16'h7FFE;
    n = 0;
    while (!buttons_valid && n < 500) begin @(posedge clk); #1; n++; end
    checks++; if (buttons_valid !== 1'b1) begin failures++; $display("FAIL irq_scan timeout valid=%b", buttons_valid); end
    checks++; if (buttons !== 16'h8001) begin failures++; $display("FAIL irq_buttons got %h want 8001", buttons); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag got %b want 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got %b want 1", irq); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h8000) begin failures++; $display("FAIL irq_changed got %h want 8000", rd); end
    bus_write(2'd1, 32'h8000);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got %b want 1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL irq_changed_clr got %h want 0", rd); end
  endtask

  task automatic test_w1c_collision;
    int n, off;
    logic [31:0] rd;
    pattern = 16'h7FFF;
    n = 0;
    while (shiftreg_loadn && n < 500) begin @(posedge clk); #1; n++; end
    checks++; if (shiftreg_loadn !== 1'b0) begin failures++; $display("FAIL w1c_start timeout loadn=%b", shiftreg_loadn); end
    off = 0;
    while (off < 128) begin @(posedge clk); #1; off++; end
    avs_address = 2'd1; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; avs_writedata = 32'd0;
    checks++; if (buttons_valid !== 1'b1) begin failures++; $display("FAIL w1c_done_align got %b want 1", buttons_valid); end
    checks++; if (buttons !== 16'h8000) begin failures++; $display("FAIL w1c_buttons got %h want 8000", buttons); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL w1c_set_wins got %h want 1", rd); end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_plain got %h want 0", rd); end
  endtask

  task automatic test_back_to_back;
    int falls, valids;
    logic prev_ld;
    bus_write(2'd3, 32'h0);
    repeat (200) @(posedge clk);
    #1;
    falls = 0; valids = 0; prev_ld = shiftreg_loadn;
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0, 20, 30: begin avs_address = 2'd3; avs_writedata = 32'h2; avs_write = 1'b1; end
        60, 200:   begin avs_address = 2'd3; avs_read = 1'b1; end
        default:   begin avs_write = 1'b0; avs_read = 1'b0; avs_writedata = 32'd0; end
      endcase
      @(posedge clk); #1;
      if (prev_ld && !shiftreg_loadn) falls++;
      prev_ld = shiftreg_loadn;
      if (buttons_valid) valids++;
      if (i == 60 || i == 200) begin
        checks++; if (avs_readdata !== 32'h4) begin failures++; $display("FAIL b2b_busy@%0d got %h want 4", i, avs_readdata); end
      end
    end
    avs_write = 1'b0; avs_read = 1'b0;
    checks++; if (falls != 2) begin failures++; $display("FAIL b2b_scans got %0d want 2", falls); end
    checks++; if (valids != 2) begin failures++; $display("FAIL b2b_valids got %0d want 2", valids); end
  endtask

  task automatic test_reset_mid;
    int n;
    bus_write(2'd3, 32'h3);
    checks++; if (shiftreg_loadn !== 1'b0) begin failures++; $display("FAIL mid_load got %b want 0", shiftreg_loadn); end
    repeat (49) @(posedge clk);
    #1;
    checks++; if (shiftreg_clk !== 1'b1) begin failures++; $display("FAIL mid_sclk_high got %b want 1", shiftreg_clk); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (shiftreg_clk !== 1'b0) begin failures++; $display("FAIL mid_rst_sclk got %b want 0", shiftreg_clk); end
    checks++; if (shiftreg_loadn !== 1'b1) begin failures++; $display("FAIL mid_rst_loadn got %b want 1", shiftreg_loadn); end
    checks++; if (buttons !== 16'h0) begin failures++; $display("FAIL mid_rst_buttons got %h want 0", buttons); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    n = 0;
    while (shiftreg_loadn && n < 600) begin @(posedge clk); #1; n++; end
    checks++; if (n != SI) begin failures++; $display("FAIL mid_restart got %0d want %0d", n, SI); end
    checks++; if (buttons !== 16'h0) begin failures++; $display("FAIL mid_buttons_kept got %h want 0", buttons); end
  endtask

`ifdef SHIFTREG_DEBOUNCE_EN
  task automatic test_debounce;
    logic [15:0] want;
    bus_write(2'd3, 32'h0);
    pattern = 16'hFFFE;
    for (int k = 1; k <= 3; k++) begin
      bus_write(2'd3, 32'h2);
      repeat (135) @(posedge clk);
      #1;
      want = (k < 3) ? 16'h0000 : 16'h0001;
      checks++; if (buttons !== want) begin failures++; $display("FAIL deb_hold%0d got %h want %h", k, buttons, want); end
    end
    pattern = 16'hFFFC;
    bus_write(2'd3, 32'h2);
    repeat (135) @(posedge clk);
    #1;
    checks++; if (buttons !== 16'h0001) begin failures++; $display("FAIL deb_glitch got %h want 0001", buttons); end
    pattern = 16'hFFFE;
    bus_write(2'd3, 32'h2);
    repeat (135) @(posedge clk);
    #1;
    checks++; if (buttons !== 16'h0001) begin failures++; $display("FAIL deb_after got %h want 0001", buttons); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset;
`ifdef SHIFTREG_DEBOUNCE_EN
    test_debounce;
`else
    test_scan;
    test_irq;
    test_w1c_collision;
    test_back_to_back;
    test_reset_mid;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
